// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR pseudo-random source.
//
// The state shifts right by one position per step, and the feedback bit
// enters at the MSB. The feedback is the parity of the tapped state bits,
// inverted in XNOR mode. OUTDATA is the top OUT_WIDTH bits of the state.
// A runtime seed can be loaded. The block detects the single lock-up state
// (all-ones for XNOR, all-zeros for XOR) and recovers from it by
// reseeding. WRAP pulses when an enabled advance returns the state to the
// value the sequence started from.
//
// Per-cycle priority, highest first:
//   RESET > LOAD > lock-up recovery > ENABLE > hold.
//
// Interface timing: ENABLE and LOAD are plain level-sampled controls with
// no backpressure. Whatever is present at a rising edge takes effect at
// that edge. STATE, OUTDATA, LOCKUP and WRAP show the result in the
// following cycle.
module lfsr_gen #(
    parameter int unsigned      WIDTH     = 19,
    parameter logic [WIDTH-1:0] TAPS      = 19'h40023,
    parameter bit               XNOR      = 1'b1,
    parameter logic [WIDTH-1:0] SEED      = 19'h1,
    parameter int unsigned      OUT_WIDTH = 5,
    parameter int unsigned      STEPS     = 1
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 ENABLE,
    input  logic                 LOAD,
    input  logic [WIDTH-1:0]     SEED_IN,
    output logic [OUT_WIDTH-1:0] OUTDATA,
    output logic [WIDTH-1:0]     STATE,
    output logic                 LOCKUP,
    output logic                 WRAP
);

    // The one state the feedback function maps onto itself.
    localparam logic [WIDTH-1:0] LOCK_VAL = {WIDTH{XNOR}};

    // The action selected this cycle is kept as a named signal so that
    // checkers and waveforms can see which priority branch won.
    typedef enum logic [1:0] {
        ACT_HOLD    = 2'd0,
        ACT_STEP    = 2'd1,
        ACT_RECOVER = 2'd2,
        ACT_LOAD    = 2'd3
    } act_e;

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic             lockup_q, lockup_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] adv_state;
    logic             is_lock;
    act_e             act;

    // One Fibonacci step. The feedback is the parity of the tapped bits,
    // flipped in XNOR mode, and it enters at the MSB.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        logic fb;
        fb = (^(s & TAPS)) ^ XNOR;
        return {fb, s[WIDTH-1:1]};
    endfunction

    // STEPS chained single steps. Each step depends on the previous one,
    // so the result is the same as STEPS separate enabled cycles at
    // STEPS=1.
    function automatic logic [WIDTH-1:0] lfsr_advance(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] v;
        v = s;
        for (int unsigned i = 0; i < STEPS; i++) begin
            v = lfsr_step(v);
        end
        return v;
    endfunction

    // Pick the winning action and compute the next register values.
    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        lockup_d  = 1'b0;
        wrap_d    = 1'b0;
        act       = ACT_HOLD;
        adv_state = lfsr_advance(state_q);
        is_lock   = (state_q == LOCK_VAL);

        if (LOAD) begin
            act = ACT_LOAD;
        end else if (is_lock) begin
            act = ACT_RECOVER;
        end else if (ENABLE) begin
            act = ACT_STEP;
        end

        case (act)
            ACT_LOAD: begin
                // A loaded seed also becomes the new reference for WRAP.
                // Loading the lock-up value is legal. Recovery follows on
                // the next cycle.
                state_d = SEED_IN;
                start_d = SEED_IN;
            end
            ACT_RECOVER: begin
                state_d  = SEED;
                start_d  = SEED;
                lockup_d = 1'b1;
            end
            ACT_STEP: begin
                // WRAP only fires when a step boundary lands exactly on
                // start. With STEPS>1, that point can differ from the
                // single-step period.
                state_d = adv_state;
                wrap_d  = (adv_state == start_q);
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // State, start reference and pulse registers. Reset clears any
    // pending pulse.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q  <= SEED;
            start_q  <= SEED;
            lockup_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            lockup_q <= lockup_d;
            wrap_q   <= wrap_d;
        end
    end

    // Outputs come straight from registers. OUTDATA is the top slice of
    // the state.
    always_comb begin
        STATE   = state_q;
        OUTDATA = state_q[WIDTH-1 -: OUT_WIDTH];
        LOCKUP  = lockup_q;
        WRAP    = wrap_q;
    end

endmodule
